// File: rtl/one_count_seq.sv
// Sequencer that hands a 16-bit word to an external ones counter, waits for its result and offers it downstream.
// Optional ONE_COUNT_SEQ_TOTAL_EN adds o_total, a 32-bit running sum of every transferred count.
module one_count_seq #(
    parameter int unsigned TIMEOUT = 31
) (
    input  logic        i_clk,
    input  logic        i_rst_,
    input  logic        i_inValid,
    output logic        o_inReady,
    input  logic [15:0] i_inData,
    output logic [15:0] o_cntData,
    output logic        o_cntRst,
    input  logic        i_cntDone,
    input  logic [15:0] i_cntCount,
    output logic        o_outValid,
    input  logic        i_outReady,
    output logic [15:0] o_outCount,
    output logic        o_err
`ifdef ONE_COUNT_SEQ_TOTAL_EN
    ,
    output logic [31:0] o_total
`endif
);

    typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_e;

    localparam logic [4:0] TIMEOUT_C = 5'(TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [15:0] count_q, count_d;
    logic [4:0]  tcnt_q, tcnt_d;
    logic        cnt_rst_q, cnt_rst_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        count_d   = count_q;
        tcnt_d    = tcnt_q;
        cnt_rst_d = 1'b0;
        valid_d   = valid_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (i_inValid) begin
                    word_d    = i_inData;
                    cnt_rst_d = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tcnt_d = tcnt_q + 5'd1;
                // tcnt_q==0 marks the first WAIT cycle, where done may still be left over from the last word
                if (i_cntDone && (tcnt_q != 5'd0)) begin
                    count_d = i_cntCount;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else if (tcnt_d == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            OUT: begin
                if (i_outReady) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_) begin
            state_q   <= IDLE;
            word_q    <= '0;
            count_q   <= '0;
            tcnt_q    <= '0;
            cnt_rst_q <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            count_q   <= count_d;
            tcnt_q    <= tcnt_d;
            cnt_rst_q <= cnt_rst_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign o_inReady  = (state_q == IDLE);
    assign o_cntData  = word_q;
    assign o_cntRst   = cnt_rst_q;
    assign o_outValid = valid_q;
    assign o_outCount = count_q;
    assign o_err      = err_q;

`ifdef ONE_COUNT_SEQ_TOTAL_EN
    logic [31:0] total_q, total_d;

    always_comb begin
        total_d = total_q;
        if ((state_q == OUT) && i_outReady) total_d = total_q + 32'(count_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_) total_q <= '0;
        else         total_q <= total_d;
    end

    assign o_total = total_q;
`endif

endmodule
